// File: rtl/bus_arbiter_pkg.sv
// Shared types and sizing helpers for the system-bus arbiter.
// State encodings are plain constants so legacy code can still compare raw values.
package bus_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACTIVE = 2'd1;
    localparam state_t ST_HOLD   = 2'd2;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    function automatic int unsigned owner_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Watchdog counter must be able to hold the limit value itself.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker with an optional fixed-priority override.
// Standalone so it can be reused for interrupt arbitration.
module rr_picker #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdxWidth = 1
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] last,
    input  logic                pri_en,
    input  logic [IdxWidth-1:0] pri_idx,
    output logic [NumReq-1:0]   pick,
    output logic [IdxWidth-1:0] pick_idx,
    output logic                valid
);

    logic [IdxWidth-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        if (pri_en && req[pri_idx]) begin
            valid    = 1'b1;
            pick_idx = pri_idx;
        end else begin
            // Scan farthest-first so the nearest requester after `last` is written last and wins.
            for (int k = int'(NumReq); k >= 1; k--) begin
                cand = IdxWidth'((int'(last) + k) % int'(NumReq));
                if (req[cand]) begin
                    valid    = 1'b1;
                    pick_idx = cand;
                end
            end
        end
        pick = '0;
        if (valid) pick[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Grants the single system-bus slave path to one requester at a time and
// holds it until completion, watchdog timeout, or the end of a locked sequence.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NumMasters     = 2,
    parameter bit          PriorityEnable = 1'b1,
    parameter int unsigned PriorityMaster = 0,
    parameter int unsigned TimeoutCycles  = DEFAULT_TIMEOUT,
    localparam int unsigned OwnerWidth    = owner_width(NumMasters)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NumMasters-1:0] req,
    input  logic [NumMasters-1:0] lock,
    input  logic                  inhibit,
    input  logic                  bus_done,
    input  logic                  bus_err,
    output logic [NumMasters-1:0] gnt,
    output logic [OwnerWidth-1:0] owner,
    output logic                  bus_valid,
    output logic [NumMasters-1:0] rsp_done,
    output logic [NumMasters-1:0] rsp_err,
    output logic                  timeout
);

    localparam int unsigned CntWidth = cnt_width(TimeoutCycles);

    state_t                state_q;
    logic [OwnerWidth-1:0] last_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [NumMasters-1:0] to_rsp_q;
    logic [NumMasters-1:0] pick;
    logic [OwnerWidth-1:0] pick_idx;
    logic                  pick_valid;
    logic                  done_now;
    logic                  timeout_hit;

    rr_picker #(
        .NumReq   (NumMasters),
        .IdxWidth (OwnerWidth)
    ) u_picker (
        .req      (req),
        .last     (last_q),
        .pri_en   (PriorityEnable),
        .pri_idx  (OwnerWidth'(PriorityMaster)),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    assign done_now    = (state_q == ST_ACTIVE) && bus_done;
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntWidth'(TimeoutCycles));

    // Completion responses are same-cycle; timeout responses come from the registered path.
    assign rsp_done = (done_now ? gnt : '0) | to_rsp_q;
    assign rsp_err  = ((done_now && bus_err) ? gnt : '0) | to_rsp_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt       <= '0;
            owner     <= '0;
            bus_valid <= 1'b0;
            last_q    <= OwnerWidth'(NumMasters - 1);
            cnt_q     <= '0;
            timeout   <= 1'b0;
            to_rsp_q  <= '0;
        end else begin
            timeout  <= 1'b0;
            to_rsp_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (!inhibit && pick_valid) begin
                        gnt       <= pick;
                        owner     <= pick_idx;
                        last_q    <= pick_idx;
                        bus_valid <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // Completion takes precedence over a watchdog expiring in the same cycle.
                    if (bus_done) begin
                        bus_valid <= 1'b0;
                        cnt_q     <= '0;
                        if (lock[owner]) begin
                            state_q <= ST_HOLD;
                        end else begin
                            gnt     <= '0;
                            state_q <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        timeout   <= 1'b1;
                        to_rsp_q  <= gnt;
                        gnt       <= '0;
                        bus_valid <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                ST_HOLD: begin
                    if (req[owner]) begin
                        bus_valid <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_ACTIVE;
                    end else if (!lock[owner]) begin
                        gnt     <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: instance 0 is round-robin with a 4-cycle watchdog,
// instance 1 is priority-to-master-0 with the watchdog disabled.
module tb_bus_arbiter;

    typedef struct packed {
        logic       id;
        logic [1:0] gnt;
    } gnt_exp_t;

    typedef struct packed {
        logic       id;
        logic [1:0] done;
        logic [1:0] err;
        logic       to;
    } rsp_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req      [2];
    logic [1:0] lock     [2];
    logic       inhibit  [2];
    logic       bus_done [2];
    logic       bus_err  [2];
    logic [1:0] gnt      [2];
    logic       owner    [2];
    logic       bus_valid[2];
    logic [1:0] rsp_done [2];
    logic [1:0] rsp_err  [2];
    logic       timeout  [2];

    gnt_exp_t   gnt_q[$];
    rsp_exp_t   rsp_q[$];
    logic [1:0] prev_gnt [2] = '{2'b00, 2'b00};
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NumMasters(2), .PriorityEnable(1'b0), .PriorityMaster(0), .TimeoutCycles(4)
    ) dut_rr (
        .clk(clk), .rst(rst), .req(req[0]), .lock(lock[0]), .inhibit(inhibit[0]),
        .bus_done(bus_done[0]), .bus_err(bus_err[0]), .gnt(gnt[0]), .owner(owner[0]),
        .bus_valid(bus_valid[0]), .rsp_done(rsp_done[0]), .rsp_err(rsp_err[0]),
        .timeout(timeout[0])
    );

    bus_arbiter #(
        .NumMasters(2), .PriorityEnable(1'b1), .PriorityMaster(0), .TimeoutCycles(0)
    ) dut_pri (
        .clk(clk), .rst(rst), .req(req[1]), .lock(lock[1]), .inhibit(inhibit[1]),
        .bus_done(bus_done[1]), .bus_err(bus_err[1]), .gnt(gnt[1]), .owner(owner[1]),
        .bus_valid(bus_valid[1]), .rsp_done(rsp_done[1]), .rsp_err(rsp_err[1]),
        .timeout(timeout[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_gnt(input int d, input logic [1:0] g);
        gnt_q.push_back({d[0], g});
    endtask

    task automatic wait_gnt(input int d);
        int n = 0;
        while (gnt[d] == 2'b00 && n < 20) begin
            step();
            n++;
        end
        check("wait_gnt", 32'(gnt[d] != 2'b00), 1);
    endtask

    // Waits for the grant, lets `delay` ACTIVE cycles pass, then completes it.
    task automatic txn(input int d, input logic [1:0] g, input int delay,
                       input logic err, input logic [1:0] req_next);
        wait_gnt(d);
        step(delay);
        rsp_q.push_back({d[0], g, (err ? g : 2'b00), 1'b0});
        bus_done[d] = 1'b1;
        bus_err[d]  = err;
        req[d]      = req_next;
        step();
        bus_done[d] = 1'b0;
        bus_err[d]  = 1'b0;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            gnt_exp_t g_obs;
            gnt_exp_t g_exp;
            rsp_exp_t r_obs;
            rsp_exp_t r_exp;
            if (gnt[d] != 2'b00 && prev_gnt[d] == 2'b00) begin
                g_obs = {d[0], gnt[d]};
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", 32'(g_obs), 0);
                end else begin
                    g_exp = gnt_q.pop_front();
                    check("gnt_seq", 32'(g_obs), 32'(g_exp));
                    check("gnt_owner", 32'(owner[d]), 32'(g_exp.gnt[1]));
                    check("gnt_valid", 32'(bus_valid[d]), 1);
                end
            end
            prev_gnt[d] = gnt[d];
            if (rsp_done[d] != 2'b00 || rsp_err[d] != 2'b00 || timeout[d]) begin
                r_obs = {d[0], rsp_done[d], rsp_err[d], timeout[d]};
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(r_obs), 0);
                end else begin
                    r_exp = rsp_q.pop_front();
                    check("rsp_seq", 32'(r_obs), 32'(r_exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [1:0] g;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 2'b00; lock[d] = 2'b00; inhibit[d] = 1'b0;
            bus_done[d] = 1'b0; bus_err[d] = 1'b0;
        end
        step(2);
        for (int d = 0; d < 2; d++) begin
            check("rst_gnt", 32'(gnt[d]), 0);
            check("rst_owner", 32'(owner[d]), 0);
            check("rst_valid", 32'(bus_valid[d]), 0);
            check("rst_rsp_done", 32'(rsp_done[d]), 0);
            check("rst_rsp_err", 32'(rsp_err[d]), 0);
            check("rst_timeout", 32'(timeout[d]), 0);
        end
        rst = 1'b0;

        // Single request from master 1, completed 3 cycles after the grant.
        req[0] = 2'b10;
        expect_gnt(0, 2'b10);
        txn(0, 2'b10, 3, 1'b0, 2'b00);
        check("t1_gnt_clear", 32'(gnt[0]), 0);
        check("t1_valid_clear", 32'(bus_valid[0]), 0);
        check("t1_owner_hold", 32'(owner[0]), 1);

        // Round-robin alternation with both requesting.
        req[0] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            expect_gnt(0, g);
            txn(0, g, 0, (i == 1), (i == 3) ? 2'b00 : 2'b11);
        end

        // Completion strobe while idle must not produce a response.
        bus_done[0] = 1'b1;
        bus_err[0]  = 1'b1;
        #1;
        check("idle_done_rsp", 32'(rsp_done[0]), 0);
        check("idle_done_err", 32'(rsp_err[0]), 0);
        step();
        bus_done[0] = 1'b0;
        bus_err[0]  = 1'b0;

        // Locked sequence by master 1 while master 0 keeps requesting.
        req[0]  = 2'b10;
        lock[0] = 2'b10;
        expect_gnt(0, 2'b10);
        txn(0, 2'b10, 1, 1'b0, 2'b01);
        check("hold_gnt", 32'(gnt[0]), 2);
        check("hold_valid", 32'(bus_valid[0]), 0);
        for (int i = 0; i < 2; i++) begin
            req[0] = 2'b11;
            step();
            check("hold_reactivate", 32'(bus_valid[0]), 1);
            check("hold_keep_gnt", 32'(gnt[0]), 2);
            rsp_q.push_back({1'b0, 2'b10, 2'b00, 1'b0});
            bus_done[0] = 1'b1;
            req[0]      = 2'b01;
            step();
            bus_done[0] = 1'b0;
            step();
            check("hold_no_preempt", 32'(gnt[0]), 2);
            check("hold_idle_valid", 32'(bus_valid[0]), 0);
        end
        lock[0] = 2'b00;
        expect_gnt(0, 2'b01);
        step();
        check("unlock_idle", 32'(gnt[0]), 0);
        txn(0, 2'b01, 0, 1'b0, 2'b00);

        // Watchdog fires one cycle after the counter reaches 4.
        req[0] = 2'b01;
        expect_gnt(0, 2'b01);
        wait_gnt(0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("to_early", 32'(timeout[0]), 0);
            check("to_keep_gnt", 32'(gnt[0]), 1);
        end
        rsp_q.push_back({1'b0, 2'b01, 2'b01, 1'b1});
        step();
        check("to_pulse", 32'(timeout[0]), 1);
        check("to_rsp_done", 32'(rsp_done[0]), 1);
        check("to_rsp_err", 32'(rsp_err[0]), 1);
        check("to_gnt_clear", 32'(gnt[0]), 0);
        check("to_valid_clear", 32'(bus_valid[0]), 0);
        req[0] = 2'b00;
        step();
        check("to_one_cycle", 32'(timeout[0]), 0);
        check("to_rsp_one_cycle", 32'(rsp_done[0]), 0);

        // Completion exactly at the limit beats the watchdog.
        req[0] = 2'b01;
        expect_gnt(0, 2'b01);
        txn(0, 2'b01, 4, 1'b0, 2'b00);
        check("limit_no_timeout", 32'(timeout[0]), 0);
        check("limit_gnt_clear", 32'(gnt[0]), 0);

        // Inhibit blocks new grants but not the current owner.
        inhibit[0] = 1'b1;
        req[0]     = 2'b11;
        for (int i = 0; i < 10; i++) begin
            step();
            check("inhibit_block", 32'(gnt[0]), 0);
        end
        expect_gnt(0, 2'b10);
        inhibit[0] = 1'b0;
        step();
        check("inhibit_release", 32'(gnt[0]), 2);
        inhibit[0] = 1'b1;
        step();
        check("inhibit_active_gnt", 32'(gnt[0]), 2);
        check("inhibit_active_valid", 32'(bus_valid[0]), 1);
        txn(0, 2'b10, 0, 1'b0, 2'b00);
        inhibit[0] = 1'b0;

        // Asynchronous reset mid-transaction, then the rotation restarts at master 0.
        req[0] = 2'b11;
        expect_gnt(0, 2'b01);
        wait_gnt(0);
        step();
        bus_done[0] = 1'b1;
        rst         = 1'b1;
        #1;
        check("arst_gnt", 32'(gnt[0]), 0);
        check("arst_valid", 32'(bus_valid[0]), 0);
        check("arst_rsp_done", 32'(rsp_done[0]), 0);
        check("arst_rsp_err", 32'(rsp_err[0]), 0);
        check("arst_owner", 32'(owner[0]), 0);
        step();
        bus_done[0] = 1'b0;
        rst         = 1'b0;
        expect_gnt(0, 2'b01);
        txn(0, 2'b01, 0, 1'b0, 2'b00);

        // Priority instance: master 0 wins every arbitration it takes part in.
        req[1] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            expect_gnt(1, 2'b01);
            txn(1, 2'b01, 0, 1'b0, (i == 3) ? 2'b10 : 2'b11);
        end
        // Watchdog disabled: a long transaction is never cut short.
        expect_gnt(1, 2'b10);
        txn(1, 2'b10, 300, 1'b1, 2'b00);
        check("pri_long_timeout", 32'(timeout[1]), 0);
        check("pri_long_gnt_clear", 32'(gnt[1]), 0);

        step(2);
        check("gnt_q_drained", 32'(gnt_q.size()), 0);
        check("rsp_q_drained", 32'(rsp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
